// File: rtl/cla_slice_seq.sv
// Multi-cycle wide adder: one SLICE-bit carry-lookahead slice is reused across
// the operand, LSB slice first, with the slice carry chained through a register.
module cla_slice_seq #(
    parameter int WIDTH = 32,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             g_all,
    output logic             p_all,
    output logic             busy,
    output logic [1:0]       fsm_state
);
    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; valid never depends on ready, and a DONE result is held until taken.
    state_t            state, state_nxt;
    logic [WIDTH-1:0]  a_r, b_r, sum_r;
    logic [IDXW-1:0]   idx;
    logic              carry_r, cout_r, g_acc, p_acc, in_ready_r;

    logic [SLICE-1:0]  sa, sb, sg, sp, ss;
    logic [SLICE:0]    sc;
    logic              slice_g, slice_p;

    // Slice lookahead: every carry is a sum of products from the slice carry-in.
    always_comb begin
        logic t;
        sa = SLICE'(a_r >> (idx * SLICE));
        sb = SLICE'(b_r >> (idx * SLICE));
        sg = sa & sb;
        sp = sa ^ sb;
        sc = '0;
        sc[0] = carry_r;
        for (int i = 0; i < SLICE; i++) begin
            t = carry_r;
            for (int k = 0; k <= i; k++) t = t & sp[k];
            sc[i+1] = t;
            for (int j = 0; j <= i; j++) begin
                t = sg[j];
                for (int k = j + 1; k <= i; k++) t = t & sp[k];
                sc[i+1] = sc[i+1] | t;
            end
        end
        ss      = sp ^ sc[SLICE-1:0];
        slice_p = &sp;
        slice_g = 1'b0;
        for (int j = 0; j < SLICE; j++) begin
            t = sg[j];
            for (int k = j + 1; k < SLICE; k++) t = t & sp[k];
            slice_g = slice_g | t;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid && in_ready_r) state_nxt = RUN;
            RUN:     if (idx == IDXW'(NSLICE - 1)) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            a_r        <= '0;
            b_r        <= '0;
            sum_r      <= '0;
            idx        <= '0;
            carry_r    <= 1'b0;
            cout_r     <= 1'b0;
            g_acc      <= 1'b0;
            p_acc      <= 1'b0;
            in_ready_r <= 1'b0;
        end else begin
            state      <= state_nxt;
            in_ready_r <= (state_nxt == IDLE);
            case (state)
                IDLE: if (in_valid && in_ready_r) begin
                    a_r     <= a;
                    b_r     <= b;
                    carry_r <= cin;
                    idx     <= '0;
                    sum_r   <= '0;
                    cout_r  <= 1'b0;
                    g_acc   <= 1'b0;
                    p_acc   <= 1'b1;
                end
                RUN: begin
                    // sum_r was cleared on accept, so OR-ing in the slice leaves upper slices at 0.
                    sum_r   <= sum_r | (WIDTH'(ss) << (idx * SLICE));
                    carry_r <= sc[SLICE];
                    g_acc   <= slice_g | (slice_p & g_acc);
                    p_acc   <= p_acc & slice_p;
                    if (idx == IDXW'(NSLICE - 1)) cout_r <= sc[SLICE];
                    else                          idx    <= idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign sum       = sum_r;
    assign cout      = cout_r;
    assign g_all     = g_acc;
    assign p_all     = p_acc;
    assign fsm_state = state;
endmodule

// File: tb/tb_cla_slice_seq.sv
// Directed bench for cla_slice_seq: expected results are queued at accept time
// and popped when the result appears.
module tb_cla_slice_seq;
    logic        clk, rst_n, in_valid, in_ready, cin, out_valid, out_ready;
    logic [31:0] a, b, sum;
    logic        cout, g_all, p_all, busy;
    logic [1:0]  fsm_state;

    int tests = 0;
    int fails = 0;
    logic [34:0] exp_q[$];

    cla_slice_seq #(.WIDTH(32), .SLICE(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .g_all(g_all), .p_all(p_all), .busy(busy),
        .fsm_state(fsm_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {sum, cout, g_all, p_all}
    function automatic logic [34:0] model(input logic [31:0] x, input logic [31:0] y, input logic c);
        logic [32:0] t, g;
        t = {1'b0, x} + {1'b0, y} + {32'd0, c};
        g = {1'b0, x} + {1'b0, y};
        return {t[31:0], t[32], g[32], &(x ^ y)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_wait", 64'(n < 20), 1);
    endtask

    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v, input logic tc, input int hold);
        logic [34:0] e;
        int n;
        wait_ready();
        a = ta; b = tb_v; cin = tc; in_valid = 1'b1;
        exp_q.push_back(model(ta, tb_v, tc));
        @(posedge clk); #1;
        in_valid = 1'b0; a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1));
        chk("busy_after_accept", busy, 1);
        chk("in_ready_in_run", in_ready, 0);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
            if (n == 1) chk("sum_upper_zero_run", sum[31:4], 0);
        end
        chk("latency", n, 8);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1; a = $urandom; b = $urandom;
            @(posedge clk); #1;
            chk("hold_sum", sum, e[34:3]);
            chk("hold_out_valid", out_valid, 1);
            chk("hold_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        chk("sum", sum, e[34:3]);
        chk("cout", cout, e[2]);
        chk("g_all", g_all, e[1]);
        chk("p_all", p_all, e[0]);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("out_valid_after_take", out_valid, 0);
        chk("in_ready_after_take", in_ready, 1);
        chk("busy_after_take", busy, 0);
    endtask

    initial begin
        logic seen;
        rst_n = 1'b0; out_ready = 1'b0;
        in_valid = 1'($urandom_range(0, 1)); a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1));
        #3;
        chk("rst_sum", sum, 0);
        chk("rst_flags", {cout, g_all, p_all, out_valid, busy}, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_state", fsm_state, 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;
        chk("in_ready_after_release", in_ready, 1);
        chk("out_valid_after_release", out_valid, 0);

        run_op(32'h0000_0001, 32'h0000_0001, 1'b0, 0);
        run_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 0);
        run_op(32'h8000_0000, 32'h8000_0000, 1'b0, 0);
        run_op(32'hDEAD_BEEF, 32'h2152_4111, 1'b0, 5);
        for (int i = 0; i < 6; i++)
            run_op($urandom, $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 2));

        // Abort mid-operation at slice index 3.
        wait_ready();
        a = 32'hFFFF_FFFF; b = 32'h0000_0001; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_state", fsm_state, 0);
        chk("abort_in_ready", in_ready, 0);
        chk("abort_sum", sum, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        chk("abort_no_out_valid", seen, 0);
        run_op(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 0);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/cla_slice_seq.md
Name: cla_slice_seq

Overview:
- Multi-cycle wide adder sequencer. Time-shares one SLICE-bit carry-lookahead slice across a WIDTH-bit operand pair.
- The slice is built from per-bit partial-full-adder terms g=a&b, p=a^b, s=p^c.
- Processes one slice per clock, LSB slice first. Chains the slice carry through a register and accumulates group generate/propagate.
- Sits between an operand producer and a result consumer, with valid/ready handshakes on both sides.

Parameters:
- WIDTH, 32, operand/sum width; must be an integer multiple of SLICE.
- SLICE, 4, bits added per cycle by the internal lookahead slice.
- NSLICE, WIDTH/SLICE, derived local parameter, not overridable; number of RUN cycles.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands a, b, cin valid
- in_ready  out  1  block can accept operands
- a  in  WIDTH  addend
- b  in  WIDTH  addend
- cin  in  1  carry into bit 0
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- sum  out  WIDTH  a+b+cin, low WIDTH bits
- cout  out  1  carry out of bit WIDTH-1
- g_all  out  1  group generate over all WIDTH bits (carry out when cin=0)
- p_all  out  1  group propagate, AND of all a[i]^b[i]
- busy  out  1  high in RUN or DONE

Behaviour:
- Reset: one clock, asynchronous active-low reset; the polarity and synchronicity are fixed.
- rst_n low forces state=IDLE and the following values, all immediately (asynchronous):
  - sum=0, cout=0, g_all=0, p_all=0, out_valid=0, busy=0
  - slice index=0, carry reg=0, operand regs=0
  - in_ready=0 while rst_n is low
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid&in_ready: latch a, b; carry reg<=cin; idx<=0; sum<=0; G_acc<=0; P_acc<=1; go to RUN.
- RUN (in_ready=0, busy=1), each cycle on slice k=idx:
  - Per-bit g/p from bits [k*SLICE +: SLICE].
  - In-slice carries use full lookahead from the carry reg, not ripple.
  - Write sum[k*SLICE +: SLICE]. Carry reg<=slice carry out.
  - G_acc<=Gs | (Ps & G_acc); P_acc<=P_acc & Ps.
  - When idx==NSLICE-1: go to DONE. Otherwise idx<=idx+1.
- DONE:
  - out_valid=1. cout=final carry reg. g_all=G_acc, p_all=P_acc.
  - sum, cout, g_all, p_all are held stable until the handshake.
  - On out_valid&out_ready: go to IDLE. in_ready rises on the next cycle.
  - No same-cycle accept in DONE; in_valid is ignored while not IDLE.
- Latency: out_valid rises exactly NSLICE clock edges after the accept edge. Throughput is at most one operation per NSLICE+2 cycles.
- Outputs are registered. sum bits of unprocessed slices read 0 during RUN.
- Operands are captured, so a/b/cin may change after accept without effect.
- Reset mid-RUN or mid-DONE aborts the operation: no out_valid, the result is discarded, return to IDLE.
- Width: the carry chain is exactly WIDTH+1 bits; no overflow flag.

Test Plan (WIDTH=32, SLICE=4):
- Assert rst_n=0 with random inputs -> all outputs 0, in_ready=0. Release -> in_ready=1 next cycle, out_valid=0.
- a=0x00000001, b=0x00000001, cin=0 -> sum=0x00000002, cout=0, g_all=0, p_all=0. out_valid exactly 8 edges after the accept edge.
- a=0xFFFFFFFF, b=0x00000000, cin=1 -> sum=0x00000000, cout=1, p_all=1, g_all=0. Checks carry propagated through all 8 slices.
- a=0x80000000, b=0x80000000, cin=0 -> sum=0x00000000, cout=1, g_all=1, p_all=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 with new operands -> outputs stable, in_ready=0, new operands not taken. Raise out_ready -> IDLE, in_ready=1 next cycle.
- Pull rst_n low during RUN at idx=3 -> immediate IDLE, out_valid never asserts. Next, a=0x12345678, b=0x9ABCDEF0, cin=0 -> sum=0xACF13568, cout=0.
